// File: rtl/prio_encoder_4to2.sv
// Serializes four request lines into a stream of 2-bit indices over valid/ready.
// Define PRIO_ENCODER_RR_EN for round-robin selection instead of fixed priority.
module prio_encoder_4to2 #(
  parameter bit PRIO_HIGH = 1'b1
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       en,
  input  logic [3:0] r,
  input  logic       ready,
  output logic [1:0] o,
  output logic       valid,
  output logic [2:0] cnt,
  output logic       ovf
);

  logic [3:0] pend;
  logic [3:0] pend_nxt;
  logic [3:0] pop_mask;
  logic [3:0] req;
  logic       pop;

  assign valid = |pend;
  assign pop   = valid && ready;
  assign req   = en ? r : 4'b0000;

  always_comb begin
    pop_mask = 4'b0000;
    if (pop) pop_mask = 4'b0001 << o;
  end

  // Set term wins, so a re-request of the popped line keeps it pending.
  assign pend_nxt = (pend & ~pop_mask) | req;

  assign cnt = {2'b00, pend[0]} + {2'b00, pend[1]}
             + {2'b00, pend[2]} + {2'b00, pend[3]};

`ifdef PRIO_ENCODER_RR_EN
  logic [1:0] ptr;

  // Scan from ptr+1 upward; the nearest hit is written last and wins.
  always_comb begin
    logic [1:0] idx;
    idx = 2'b00;
    o   = 2'b00;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (pend[idx]) o = idx;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ptr <= 2'b11;
    end else if (pop) begin
      ptr <= o;
    end
  end
`else
  always_comb begin
    o = 2'b00;
    if (PRIO_HIGH) begin
      for (int i = 0; i < 4; i++)
        if (pend[i]) o = 2'(i);
    end else begin
      for (int i = 3; i >= 0; i--)
        if (pend[i]) o = 2'(i);
    end
  end
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pend <= 4'b0000;
      ovf  <= 1'b0;
    end else begin
      pend <= pend_nxt;
      ovf  <= |(req & pend & ~pop_mask);
    end
  end

endmodule
